// File: rtl/gate_check_pkg.sv
// Shared definitions for the gate truth-table checker.
//   state_t    : sweep controller states
//   vec_count  : number of input vectors swept for an n-input gate network
`timescale 1ns/1ps
package gate_check_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    function automatic int vec_count(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/gate_settle_timer.sv
// Settle-time down-counter for the gate checker.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : (re)start the count; expire fires SETTLE cycles later,
//                counting the first cycle after load as cycle 1
//   expire     : single-cycle pulse when the loaded count reaches zero
`timescale 1ns/1ps
module gate_settle_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expire
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

    logic [CW-1:0] cnt;
    logic          armed;

    // Loading SETTLE-1 makes the terminal count land on the SETTLE-th cycle.
    assign expire = armed && (cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            armed <= 1'b0;
        end else if (load) begin
            cnt   <= CW'(SETTLE - 1);
            armed <= 1'b1;
        end else if (expire) begin
            armed <= 1'b0;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/gate_truth_checker.sv
// Sweeps every input vector into a combinational gate network, samples the
// response after a settle time and compares it with an expected truth table.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : request a sweep (accepted only in IDLE)
//   dut_in     : vector driven into the gate network (descending sweep)
//   dut_out    : gate network response; X/Z counts as a mismatch
//   busy       : sweep in progress
//   done       : one-cycle pulse at sweep completion
//   pass       : last sweep had no mismatches
//   fail_idx   : first (highest) mismatching vector of last sweep, 0 if none
//   err_count  : mismatches in last sweep
//   observed   : measured truth table, only when OBSERVED_TABLE_EN is defined
//
// state  | meaning
// IDLE   | waiting for start
// DRIVE  | holding dut_in for SETTLE cycles
// SAMPLE | compare dut_out against EXPECTED[idx], step to next vector
// FINISH | publish pass/done, return dut_in to 0
`timescale 1ns/1ps
module gate_truth_checker
    import gate_check_pkg::*;
#(
    parameter int                   N_IN     = 2,
    parameter logic [(1<<N_IN)-1:0] EXPECTED = 4'b1110,
    parameter int                   SETTLE   = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN-1:0] fail_idx,
    output logic [N_IN:0]   err_count
`ifdef OBSERVED_TABLE_EN
    ,
    output logic [(1<<N_IN)-1:0] observed
`endif
);

    localparam int              VEC      = vec_count(N_IN);
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(VEC - 1);

    state_t          state, state_nxt;
    logic [N_IN-1:0] idx;
    logic            timer_load;
    logic            timer_expire;
    logic            mismatch;

    gate_settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (timer_load),
        .expire (timer_expire)
    );

    // Case-inequality so an undriven or X response is flagged, not masked.
    assign mismatch = (dut_out !== EXPECTED[idx]);

    always_comb begin
        state_nxt  = state;
        timer_load = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt  = DRIVE;
                    timer_load = 1'b1;
                end
            end
            DRIVE: begin
                if (timer_expire) state_nxt = SAMPLE;
            end
            SAMPLE: begin
                if (idx == '0) begin
                    state_nxt = FINISH;
                end else begin
                    state_nxt  = DRIVE;
                    timer_load = 1'b1;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            dut_in    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_idx  <= '0;
            err_count <= '0;
`ifdef OBSERVED_TABLE_EN
            observed  <= '0;
`endif
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx       <= LAST_IDX;
                        dut_in    <= LAST_IDX;
                        err_count <= '0;
                        fail_idx  <= '0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
`ifdef OBSERVED_TABLE_EN
                        observed  <= '0;
`endif
                    end
                end
                SAMPLE: begin
                    if (mismatch) begin
                        err_count <= err_count + 1'b1;
                        // Descending sweep: the first mismatch is the highest vector.
                        if (err_count == '0) fail_idx <= idx;
                    end
`ifdef OBSERVED_TABLE_EN
                    observed[idx] <= dut_out;
`endif
                    if (idx != '0) begin
                        idx    <= idx - 1'b1;
                        dut_in <= idx - 1'b1;
                    end
                end
                FINISH: begin
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    pass   <= (err_count == '0);
                    dut_in <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
